// File: rtl/mm_pkg.sv
// mm_pkg: shared state type and sizing helpers for the systolic array sequencer
package mm_pkg;
   localparam int DEFAULT_WIDTH = 8;
   typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, UNLOAD, DONE} state_e;
   function automatic int drain_cycles(input int n);
      return 2 * n;
   endfunction
endpackage

// File: rtl/skew_line.sv
// skew_line: DEPTH-stage {valid, data} delay line; DEPTH = 0 passes straight through
module skew_line #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             d_valid,
   input  logic [WIDTH-1:0] d_data,
   output logic             q_valid,
   output logic [WIDTH-1:0] q_data
);
   localparam int LEN = DEPTH > 0 ? DEPTH : 1;
   logic [WIDTH:0] regs [LEN];
   always_ff @(posedge clk or posedge reset)
      if (reset)
         for (int s = 0; s < LEN; s++) regs[s] <= '0;
      else begin
         regs[0] <= {d_valid, d_data};
         for (int s = 1; s < LEN; s++) regs[s] <= regs[s-1];
      end
   assign {q_valid, q_data} = DEPTH == 0 ? {d_valid, d_data} : regs[LEN-1];
endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: clears, feeds (skewed), drains and unloads an N x N systolic mac array
module systolic_ctrl import mm_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int N     = 4,
   parameter int K_MAX = 16,
   parameter int KW    = $clog2(K_MAX + 1),
   parameter int AW    = $clog2(K_MAX)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [KW-1:0]        k_len,
   output logic                 busy,
   output logic                 done,
   output logic                 rd_en,
   output logic [AW-1:0]        rd_addr,
   input  logic [N*WIDTH-1:0]   a_rd_data,
   input  logic [N*WIDTH-1:0]   b_rd_data,
   output logic [N*WIDTH-1:0]   arr_a,
   output logic [N-1:0]         arr_valid_a,
   output logic [N*WIDTH-1:0]   arr_b,
   output logic [N-1:0]         arr_valid_b,
   output logic                 arr_clr_n,
   output logic [$clog2(N)-1:0] res_row,
   output logic                 res_valid,
   input  logic                 res_ready
);
   localparam int DRAIN_LEN = drain_cycles(N);
   localparam int DW = $clog2(DRAIN_LEN);
   localparam int CW = KW > DW ? KW : DW;
   localparam int RW = $clog2(N);
   state_e state, state_nx;
   logic [KW-1:0] kq;
   logic [CW-1:0] cnt, cnt_nx;
   logic [RW-1:0] row_nx;
   logic valid_d;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state     <= IDLE;
         kq        <= '0;
         cnt       <= '0;
         res_row   <= '0;
         valid_d   <= 1'b0;
         arr_clr_n <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         res_row   <= row_nx;
         valid_d   <= rd_en;
         arr_clr_n <= state_nx != CLEAR;
         if (state == IDLE && start) kq <= k_len > KW'(K_MAX) ? KW'(K_MAX) : k_len;
      end
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      row_nx   = res_row;
      case (state)
         IDLE: state_nx = start ? CLEAR : IDLE;
         CLEAR: begin
            state_nx = kq != '0 ? FEED : UNLOAD;
            cnt_nx   = '0;
            row_nx   = '0;
         end
         FEED: begin
            cnt_nx = cnt + 1'b1;
            if (cnt == CW'(kq) - CW'(1)) begin
               state_nx = DRAIN;
               cnt_nx   = '0;
            end
         end
         DRAIN: begin
            cnt_nx = cnt + 1'b1;
            if (cnt == CW'(DRAIN_LEN - 1)) begin
               state_nx = UNLOAD;
               row_nx   = '0;
            end
         end
         UNLOAD: if (res_ready) begin
            row_nx   = res_row + 1'b1;
            state_nx = res_row == RW'(N - 1) ? DONE : UNLOAD;
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   assign busy      = state != IDLE;
   assign done      = state == DONE;
   assign rd_en     = state == FEED;
   assign rd_addr   = rd_en ? cnt[AW-1:0] : '0;
   assign res_valid = state == UNLOAD;
   // row i and column i both sit i registers behind the read-data register
   genvar i;
   for (i = 0; i < N; i++) begin : g_edge
      logic va, vb;
      logic [WIDTH-1:0] da, db;
      skew_line #(.WIDTH(WIDTH), .DEPTH(i)) u_a (
         .clk(clk), .reset(reset), .d_valid(valid_d), .d_data(a_rd_data[i*WIDTH +: WIDTH]),
         .q_valid(va), .q_data(da));
      skew_line #(.WIDTH(WIDTH), .DEPTH(i)) u_b (
         .clk(clk), .reset(reset), .d_valid(valid_d), .d_data(b_rd_data[i*WIDTH +: WIDTH]),
         .q_valid(vb), .q_data(db));
      assign arr_valid_a[i]          = va;
      assign arr_valid_b[i]          = vb;
      assign arr_a[i*WIDTH +: WIDTH] = va ? da : '0;
      assign arr_b[i*WIDTH +: WIDTH] = vb ? db : '0;
   end
endmodule
